// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 16-bit ALU and its issue/writeback controller:
// datapath and register-file sizes, the controller state encoding and the
// ALU opcode map. The opcode map is owned here so that the ALU and every
// producer of commands agree on it.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int WIDTH  = 16;
    localparam int OPC_W  = 3;
    localparam int NREG   = 8;
    localparam int REG_AW = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // ALU opcodes; the controller forwards them untouched.
    localparam logic [OPC_W-1:0] OPC_ADD   = 3'd0;
    localparam logic [OPC_W-1:0] OPC_SUB   = 3'd1;
    localparam logic [OPC_W-1:0] OPC_AND   = 3'd2;
    localparam logic [OPC_W-1:0] OPC_OR    = 3'd3;
    localparam logic [OPC_W-1:0] OPC_XOR   = 3'd4;
    localparam logic [OPC_W-1:0] OPC_PASSA = 3'd5;
    localparam logic [OPC_W-1:0] OPC_PASSB = 3'd6;
    localparam logic [OPC_W-1:0] OPC_NOT   = 3'd7;

endpackage

// File: rtl/alu_regfile.sv
// ---------------------------------------------------------------------------
// alu_regfile
// NREG x WIDTH register file with two combinational read ports and one
// synchronous write port. Register 0 always reads as zero and ignores
// writes. Synchronous reset clears every entry.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ra_a, ra_b      read addresses
//   rd_a, rd_b      read data (combinational)
//   we, wa, wd      write enable, address, data (written at rising edge)
// ---------------------------------------------------------------------------
module alu_regfile
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    ra_a,
    input  logic [AW-1:0]    ra_b,
    output logic [WIDTH-1:0] rd_a,
    output logic [WIDTH-1:0] rd_b,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd
);

    logic [WIDTH-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    // R0 is forced to zero on the read side as well, so it stays zero even
    // if the storage bit for entry 0 is ever disturbed.
    assign rd_a = (ra_a == '0) ? '0 : regs[ra_a];
    assign rd_b = (ra_b == '0) ? '0 : regs[ra_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Issue/writeback controller in front of an external combinational ALU.
// Accepts one command at a time, reads operands from the internal register
// file, holds the ALU inputs stable through a full execute cycle, writes the
// ALU result back and presents result + flags on a response channel.
// Sequence: IDLE -> EXEC -> RESP -> IDLE (one command per 3 cycles peak).
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_opc, cmd_sa, cmd_sb, cmd_dst  opcode, source A/B, destination index
//   cmd_cin                           carry-in for the ALU
//   cmd_imm_en, cmd_imm               operand B from immediate when set
//   alu_a, alu_b, alu_c, alu_opc      registered ALU inputs
//   alu_w, alu_zer, alu_neg           ALU result and flags
//   rsp_valid/rsp_ready               response handshake
//   rsp_w, rsp_zer, rsp_neg           captured result and flags
// ---------------------------------------------------------------------------
module alu_issue_ctrl
#(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [alu_pkg::OPC_W-1:0] cmd_opc,
    input  logic [AW-1:0]             cmd_sa,
    input  logic [AW-1:0]             cmd_sb,
    input  logic [AW-1:0]             cmd_dst,
    input  logic                      cmd_cin,
    input  logic                      cmd_imm_en,
    input  logic [WIDTH-1:0]          cmd_imm,
    output logic [WIDTH-1:0]          alu_a,
    output logic [WIDTH-1:0]          alu_b,
    output logic                      alu_c,
    output logic [alu_pkg::OPC_W-1:0] alu_opc,
    input  logic [WIDTH-1:0]          alu_w,
    input  logic                      alu_zer,
    input  logic                      alu_neg,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [WIDTH-1:0]          rsp_w,
    output logic                      rsp_zer,
    output logic                      rsp_neg
);

    import alu_pkg::*;

    state_t           state;
    state_t           state_nxt;
    logic [AW-1:0]    dst_q;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic             accept;
    logic             wb_en;

    assign accept = cmd_valid && cmd_ready;
    assign wb_en  = (state == S_EXEC);

    alu_regfile #(
        .WIDTH (WIDTH),
        .NREG  (NREG)
    ) u_regfile (
        .clk  (clk),
        .rst  (rst),
        .ra_a (cmd_sa),
        .ra_b (cmd_sb),
        .rd_a (rd_a),
        .rd_b (rd_b),
        .we   (wb_en),
        .wa   (dst_q),
        .wd   (alu_w)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept)    state_nxt = S_EXEC;
            S_EXEC:                 state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    // Output logic; ready is masked during reset so a command presented in
    // the reset cycle is never taken.
    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            S_IDLE:  cmd_ready = !rst;
            S_RESP:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Issue stage: operands latched on accept and held until the next accept
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_c   <= 1'b0;
            alu_opc <= '0;
            dst_q   <= '0;
        end else if (accept) begin
            alu_a   <= rd_a;
            alu_b   <= cmd_imm_en ? cmd_imm : rd_b;
            alu_c   <= cmd_cin;
            alu_opc <= cmd_opc;
            dst_q   <= cmd_dst;
        end
    end

    // Writeback stage: result and flags captured at the end of EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_w   <= '0;
            rsp_zer <= 1'b0;
            rsp_neg <= 1'b0;
        end else if (state == S_EXEC) begin
            rsp_w   <= alu_w;
            rsp_zer <= alu_zer;
            rsp_neg <= alu_neg;
        end
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential issue/writeback controller that sits directly upstream of the 16-bit combinational ALU (ports inA, inB, inC, opc → outW, zer, neg) and consumes its results. The block accepts one command at a time over a valid/ready handshake. It reads operands from an internal 8×16 register file, holds the ALU inputs stable for one full execute cycle, writes outW back to a destination register, and returns the result and flags over a valid/ready response channel.

## Interface
Parameters:
- WIDTH, 16, datapath width; must match the ALU.
- NREG, 8, number of registers; index width is log2(NREG) = 3.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_opc  in  3  ALU opcode, passed through unchanged.
- cmd_sa  in  3  source-A register index.
- cmd_sb  in  3  source-B register index.
- cmd_dst  in  3  destination register index.
- cmd_cin  in  1  carry-in, driven to ALU inC.
- cmd_imm_en  in  1  1 = operand B taken from cmd_imm instead of register cmd_sb.
- cmd_imm  in  WIDTH  immediate operand.
- alu_a  out  WIDTH  to ALU inA (registered).
- alu_b  out  WIDTH  to ALU inB (registered).
- alu_c  out  1  to ALU inC (registered).
- alu_opc  out  3  to ALU opc (registered).
- alu_w  in  WIDTH  from ALU outW.
- alu_zer  in  1  from ALU zer.
- alu_neg  in  1  from ALU neg.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_w  out  WIDTH  captured result.
- rsp_zer  out  1  captured zero flag.
- rsp_neg  out  1  captured negative flag.

## Operation
State machine: IDLE → EXEC → RESP → IDLE.
- **IDLE**
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: alu_a←R[sa], alu_b←(imm_en ? imm : R[sb]), alu_c←cin, alu_opc←opc, latch dst; go to EXEC.
- **EXEC**
  - cmd_ready=0; ALU inputs held constant.
  - At the end of the cycle: rsp_w/zer/neg←alu_w/zer/neg, R[dst]←alu_w, go to RESP.
- **RESP**
  - rsp_valid=1; rsp_* and alu_* held stable.
  - On rsp_ready: go to IDLE.
  - A stalled rsp_ready holds the block in RESP indefinitely; no new command is accepted.
- **Register file**
  - R0 reads as 0 always; writes to R0 are discarded, but the response still carries alu_w.
  - Registers are written only by writeback. Software seeds them with immediate commands, e.g. sa=R0, imm_en=1, and an ALU pass/add opcode.
- **Operand reads** are combinational from the register file in IDLE. Commands are serialized, so no RAW hazard exists and no bypass is needed.
- **Width rules**: no width conversion anywhere. alu_w is stored as-is, and flags are taken only from the ALU, never recomputed.

## Timing
- Command accepted at edge n. EXEC occupies cycle n..n+1. Writeback and response capture happen at edge n+1. rsp_valid is high from edge n+1.
- With rsp_ready tied high, rsp_valid is high for exactly one cycle, and the next command can be accepted at edge n+3. Peak throughput is 1 command / 3 cycles.
- A result written at edge n+1 is visible to a command accepted at edge n+3 or later.
- Reset values:
  - state=IDLE.
  - All R[i]=0.
  - alu_a=alu_b=0, alu_c=0, alu_opc=0.
  - rsp_w=0, rsp_zer=0, rsp_neg=0, rsp_valid=0.
  - cmd_ready=0 during the reset cycle, 1 after it.
- Reset asserted in EXEC or RESP aborts the operation: no writeback, no response, and all outputs take their reset values at that edge.
- In IDLE, cmd_valid with cmd_ready=0 (reset cycle) is ignored.

## Structure
- Shared package alu_pkg:
  - WIDTH=16, OPC_W=3, NREG=8, REG_AW=3.
  - State enum {S_IDLE, S_EXEC, S_RESP}.
  - ALU opcode localparams, shared with the ALU.
- Sub-module alu_regfile: NREG×WIDTH, two combinational read ports, one synchronous write port, R0 hardwired zero, synchronous reset clears contents.
- alu_issue_ctrl instantiates alu_regfile plus the FSM. The ALU itself is external, so the bench can drive a stub or the real ALU.

## Test plan
- **Reset**: hold rst 2 cycles with cmd_valid=1. Required: all outputs 0, no command accepted, cmd_ready=1 on the first cycle after rst falls.
- **Immediate load**: cmd sa=R0, imm_en=1, imm=16'h1234, dst=R3, ALU stub returns alu_w=A+B. Required: alu_a=0 and alu_b=16'h1234 during EXEC; rsp_w=16'h1234, zer=0, neg=0 at edge n+1; a later read shows R3=16'h1234.
- **Register operands and flags**:
  - R1=16'h8000, R2=16'h8000, stub add: rsp_w=16'h0000, zer=1.
  - R1=16'hFFFF, R2=0: neg=1.
  - cin=1 appears on alu_c.
- **R0 write**: dst=R0 with stub result 16'hBEEF. Required: rsp_w=16'hBEEF, R0 still reads 0.
- **Backpressure**: rsp_ready=0 for 5 cycles while cmd_valid=1. Required: rsp_* stable, cmd_ready=0 throughout; one cycle after rsp_ready=1, cmd_ready=1 and the queued command is accepted.
- **Reset mid-operation**: assert rst in EXEC with dst=R5. Required: R5 unchanged (0), rsp_valid never asserts, state returns to IDLE.
